// File: rtl/frog_tone_player.sv
// frog_tone_player: plays a four-note win/lose jingle as a square wave on each start request
//
// Ports:
//    clk           - system clock
//    resetN        - asynchronous active-low reset
//    enable_sound  - sound request level; a rising edge starts a melody when idle
//    sound_freq_in - melody select: 0 = lose (descending), 1 = win (ascending), others ignored
//    tone_out      - square-wave audio output, low between melodies and at each note start
//    busy          - high while a melody is playing
//    note_idx      - index of the note currently playing (0..3)
//    done          - one-cycle pulse in the final cycle of the last note
//
// Optional feature: define TONE_GAP_EN to insert GAP_LEN silent cycles between notes.
module frog_tone_player #(
   parameter int NOTE_LEN = 12500000,
   parameter int GAP_LEN  = 2500000,
   parameter int HP_SHIFT = 0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       enable_sound,
   input  logic [9:0] sound_freq_in,
   output logic       tone_out,
   output logic       busy,
   output logic [1:0] note_idx,
   output logic       done
);

   if (NOTE_LEN < 1 || GAP_LEN < 1) begin : g_bad_params
      $error("frog_tone_player: NOTE_LEN and GAP_LEN must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      PLAY
`ifdef TONE_GAP_EN
      , GAP
`endif
   } state_t;

   localparam logic [31:0] NOTE_M1 = 32'(NOTE_LEN - 1);
`ifdef TONE_GAP_EN
   localparam logic [31:0] GAP_M1 = 32'(GAP_LEN - 1);
`endif

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic [1:0]  note_q, note_d;
   logic [16:0] half_q, half_d;
   logic [31:0] dur_q, dur_d;
   logic        tone_q, tone_d;
   logic        en_q;
   logic        start;
   logic [16:0] hp_start, hp_cur, hp_next;

   // Half-period ROM after scaling; a shift that empties the value is clamped to 1.
   function automatic logic [16:0] hp_of(input logic win, input logic [1:0] idx);
      logic [16:0] raw;
      logic [16:0] sh;
      case ({win, idx})
         3'b100:  raw = 17'd47801;
         3'b101:  raw = 17'd37936;
         3'b110:  raw = 17'd31888;
         3'b111:  raw = 17'd23877;
         3'b000:  raw = 17'd63776;
         3'b001:  raw = 17'd75757;
         default: raw = 17'd95420;
      endcase
      sh = raw >> HP_SHIFT;
      return (sh == 17'd0) ? 17'd1 : sh;
   endfunction

   assign hp_start = hp_of(sound_freq_in[0], 2'd0);
   assign hp_cur   = hp_of(sel_q, note_q);
   assign hp_next  = hp_of(sel_q, note_q + 2'd1);
   // Only a fresh rising edge with a valid select starts a melody; en_q keeps tracking while busy.
   assign start    = enable_sound & ~en_q & (sound_freq_in[9:1] == 9'd0);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      note_d  = note_q;
      half_d  = half_q;
      dur_d   = dur_q;
      tone_d  = tone_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            tone_d = 1'b0;
            if (start) begin
               sel_d   = sound_freq_in[0];
               note_d  = 2'd0;
               half_d  = hp_start - 17'd1;
               dur_d   = NOTE_M1;
               state_d = PLAY;
            end
         end
         PLAY: begin
            dur_d  = dur_q - 32'd1;
            half_d = (half_q == 17'd0) ? hp_cur - 17'd1 : half_q - 17'd1;
            tone_d = (half_q == 17'd0) ? ~tone_q : tone_q;
            // Note boundary wins over a coincident toggle so every note starts low.
            if (dur_q == 32'd0) begin
               tone_d = 1'b0;
               if (note_q == 2'd3) begin
                  done    = 1'b1;
                  note_d  = 2'd0;
                  state_d = IDLE;
               end else begin
`ifdef TONE_GAP_EN
                  dur_d   = GAP_M1;
                  state_d = GAP;
`else
                  note_d  = note_q + 2'd1;
                  half_d  = hp_next - 17'd1;
                  dur_d   = NOTE_M1;
`endif
               end
            end
         end
`ifdef TONE_GAP_EN
         GAP: begin
            tone_d = 1'b0;
            dur_d  = dur_q - 32'd1;
            if (dur_q == 32'd0) begin
               note_d  = note_q + 2'd1;
               half_d  = hp_next - 17'd1;
               dur_d   = NOTE_M1;
               state_d = PLAY;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // en_q resets high so a request already asserted at reset release does not start playback.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         note_q  <= 2'd0;
         half_q  <= 17'd0;
         dur_q   <= 32'd0;
         tone_q  <= 1'b0;
         en_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         note_q  <= note_d;
         half_q  <= half_d;
         dur_q   <= dur_d;
         tone_q  <= tone_d;
         en_q    <= enable_sound;
      end
   end

   assign tone_out = tone_q;
   assign busy     = (state_q != IDLE);
   assign note_idx = note_q;

endmodule
